// File: rtl/reaction_stats.sv
// reaction_stats: best time, 4-trial moving average and outcome counters
// for the reaction-timer game, with every figure re-encoded as BCD.
module reaction_stats #(
    parameter int CNT_W   = 8,
    parameter int WIN_LOG = 2
) (
    input  logic             CLK100MHZ,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             result_valid,
    input  logic [1:0]       result_kind,
    input  logic [15:0]      result_bcd,
    output logic             in_ready,
    output logic             stats_valid,
    output logic [15:0]      best_bcd,
    output logic             best_valid,
    output logic [15:0]      avg_bcd,
    output logic             avg_valid,
    output logic [CNT_W-1:0] trial_cnt,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic [CNT_W-1:0] cheat_cnt,
    output logic             overrun
);
    localparam int WIN = 1 << WIN_LOG;
    localparam logic [WIN_LOG:0] FULL = (WIN_LOG + 1)'(WIN);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CONV   = 3'd1;
    localparam logic [2:0] UPDATE = 3'd2;
    localparam logic [2:0] DABBLE = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]         state;
    logic [3:0]         phase;
    logic [15:0]        capBcd;
    logic [13:0]        binVal;
    logic [13:0]        ring [WIN];
    logic [WIN_LOG-1:0] wp;
    logic [WIN_LOG:0]   fill;
    logic [15:0]        sum;
    logic [13:0]        bestBin;
    logic               bestSeen;
    logic [29:0]        dabBest;
    logic [29:0]        dabAvg;

    logic [3:0]         digit;
    logic [13:0]        convNext;
    logic [15:0]        newSum;
    logic [13:0]        avgBin;
    logic [13:0]        nextBest;
    logic [29:0]        stepBest;
    logic [29:0]        stepAvg;

    // One double-dabble iteration on {bcd[15:0], bin[13:0]}
    function automatic logic [29:0] dabbleStep(input logic [29:0] v);
        logic [29:0] t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            if (t[14+4*i +: 4] >= 4'd5)
                t[14+4*i +: 4] = t[14+4*i +: 4] + 4'd3;
        end
        return {t[28:0], 1'b0};
    endfunction

    assign in_ready    = (state == IDLE);
    assign stats_valid = (state == DONE);

    always_comb begin
        digit    = (capBcd[15:12] > 4'd9) ? 4'd9 : capBcd[15:12];
        convNext = (binVal << 3) + (binVal << 1) + {10'd0, digit};
        newSum   = sum - {2'b00, ring[wp]} + {2'b00, binVal};
        avgBin   = 14'(newSum >> WIN_LOG);
        nextBest = (!bestSeen || binVal < bestBin) ? binVal : bestBin;
        stepBest = dabbleStep(dabBest);
        stepAvg  = dabbleStep(dabAvg);
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n || clear) begin
            state       <= IDLE;
            phase       <= '0;
            capBcd      <= '0;
            binVal      <= '0;
            wp          <= '0;
            fill        <= '0;
            sum         <= '0;
            bestBin     <= 14'd9999;
            bestSeen    <= 1'b0;
            dabBest     <= '0;
            dabAvg      <= '0;
            best_bcd    <= 16'h9999;
            best_valid  <= 1'b0;
            avg_bcd     <= '0;
            avg_valid   <= 1'b0;
            trial_cnt   <= '0;
            timeout_cnt <= '0;
            cheat_cnt   <= '0;
            overrun     <= 1'b0;
            for (int i = 0; i < WIN; i++)
                ring[i] <= '0;
        end else begin
            if (result_valid && !in_ready)
                overrun <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (result_valid) begin
                        capBcd <= result_bcd;
                        binVal <= '0;
                        phase  <= '0;
                        if (result_kind == 2'd0) begin
                            state <= CONV;
                        end else begin
                            state <= DONE;
                            if (result_kind == 2'd1) begin
                                if (timeout_cnt != '1)
                                    timeout_cnt <= timeout_cnt + CNT_W'(1);
                            end else if (cheat_cnt != '1) begin
                                cheat_cnt <= cheat_cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                CONV: begin
                    binVal <= convNext;
                    capBcd <= {capBcd[11:0], 4'h0};
                    phase  <= phase + 4'd1;
                    if (phase == 4'd3)
                        state <= UPDATE;
                end
                UPDATE: begin
                    sum      <= newSum;
                    ring[wp] <= binVal;
                    wp       <= wp + WIN_LOG'(1);
                    if (fill != FULL)
                        fill <= fill + (WIN_LOG + 1)'(1);
                    bestBin  <= nextBest;
                    bestSeen <= 1'b1;
                    dabBest  <= {16'h0000, nextBest};
                    dabAvg   <= {16'h0000, avgBin};
                    phase    <= '0;
                    state    <= DABBLE;
                end
                DABBLE: begin
                    dabBest <= stepBest;
                    dabAvg  <= stepAvg;
                    phase   <= phase + 4'd1;
                    // Last iteration: publish everything together on entry to DONE
                    if (phase == 4'd13) begin
                        best_bcd   <= stepBest[29:14];
                        best_valid <= 1'b1;
                        if (fill == FULL)
                            avg_bcd <= stepAvg[29:14];
                        avg_valid  <= (fill == FULL);
                        if (trial_cnt != '1)
                            trial_cnt <= trial_cnt + CNT_W'(1);
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reaction_stats.sv
// Bench for reaction_stats: vector table through a scoreboard queue,
// plus hand-written overrun, clear and saturation sequences.
module tb_reaction_stats;
    typedef struct {
        logic [1:0]  kind;
        logic [15:0] bcd;
        logic [15:0] best;
        logic        bv;
        logic [15:0] avg;
        logic        av;
        int          trial;
        int          tmo;
        int          cht;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        result_valid;
    logic [1:0]  result_kind;
    logic [15:0] result_bcd;
    logic        in_ready;
    logic        stats_valid;
    logic [15:0] best_bcd;
    logic        best_valid;
    logic [15:0] avg_bcd;
    logic        avg_valid;
    logic [7:0]  trial_cnt;
    logic [7:0]  timeout_cnt;
    logic [7:0]  cheat_cnt;
    logic        overrun;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    vec_t sb[$];
    vec_t tbl[12];

    reaction_stats dut (
        .CLK100MHZ    (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .result_valid (result_valid),
        .result_kind  (result_kind),
        .result_bcd   (result_bcd),
        .in_ready     (in_ready),
        .stats_valid  (stats_valid),
        .best_bcd     (best_bcd),
        .best_valid   (best_valid),
        .avg_bcd      (avg_bcd),
        .avg_valid    (avg_valid),
        .trial_cnt    (trial_cnt),
        .timeout_cnt  (timeout_cnt),
        .cheat_cnt    (cheat_cnt),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkCleared(input string tag);
        chk({tag, "_best"}, 32'(best_bcd), 32'h9999);
        chk({tag, "_bv"}, 32'(best_valid), 0);
        chk({tag, "_avg"}, 32'(avg_bcd), 0);
        chk({tag, "_av"}, 32'(avg_valid), 0);
        chk({tag, "_trial"}, 32'(trial_cnt), 0);
        chk({tag, "_tmo"}, 32'(timeout_cnt), 0);
        chk({tag, "_cht"}, 32'(cheat_cnt), 0);
        chk({tag, "_ovr"}, 32'(overrun), 0);
        chk({tag, "_rdy"}, 32'(in_ready), 1);
        chk({tag, "_sv"}, 32'(stats_valid), 0);
    endtask

    task automatic sendResult(input vec_t v, input bit push, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_wait: in_ready %0d expected 1", in_ready);
        end
        result_valid = 1'b1;
        result_kind  = v.kind;
        result_bcd   = v.bcd;
        if (push)
            sb.push_back(v);
        acc = cyc + 1;
        @(negedge clk);
        result_valid = 1'b0;
    endtask

    task automatic waitStats(input int acc, input string tag);
        int   n;
        vec_t e;
        n = 0;
        while (!stats_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!stats_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: stats_valid 0 expected 1", tag);
            if (sb.size() > 0)
                void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        chk({tag, "_lat"}, 32'(cyc + 1 - acc), 32'(e.lat));
        chk({tag, "_best"}, 32'(best_bcd), 32'(e.best));
        chk({tag, "_bv"}, 32'(best_valid), 32'(e.bv));
        chk({tag, "_avg"}, 32'(avg_bcd), 32'(e.avg));
        chk({tag, "_av"}, 32'(avg_valid), 32'(e.av));
        chk({tag, "_trial"}, 32'(trial_cnt), 32'(e.trial));
        chk({tag, "_tmo"}, 32'(timeout_cnt), 32'(e.tmo));
        chk({tag, "_cht"}, 32'(cheat_cnt), 32'(e.cht));
        chk({tag, "_busy"}, 32'(in_ready), 0);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(stats_valid), 0);
        chk({tag, "_ready"}, 32'(in_ready), 1);
    endtask

    initial begin
        int   acc;
        int   pulses;
        vec_t v;

        rst_n        = 1'b0;
        clear        = 1'b0;
        result_valid = 1'b0;
        result_kind  = 2'd0;
        result_bcd   = 16'h0000;

        tbl[0]  = '{2'd0, 16'h0347, 16'h0347, 1'b1, 16'h0000, 1'b0, 1, 0, 0, 20};
        tbl[1]  = '{2'd0, 16'h0250, 16'h0250, 1'b1, 16'h0000, 1'b0, 2, 0, 0, 20};
        tbl[2]  = '{2'd0, 16'h0300, 16'h0250, 1'b1, 16'h0000, 1'b0, 3, 0, 0, 20};
        tbl[3]  = '{2'd0, 16'h0350, 16'h0250, 1'b1, 16'h0311, 1'b1, 4, 0, 0, 20};
        tbl[4]  = '{2'd0, 16'h0401, 16'h0250, 1'b1, 16'h0325, 1'b1, 5, 0, 0, 20};
        tbl[5]  = '{2'd0, 16'h0100, 16'h0100, 1'b1, 16'h0287, 1'b1, 6, 0, 0, 20};
        tbl[6]  = '{2'd1, 16'h0000, 16'h0100, 1'b1, 16'h0287, 1'b1, 6, 1, 0, 1};
        tbl[7]  = '{2'd2, 16'h1234, 16'h0100, 1'b1, 16'h0287, 1'b1, 6, 1, 1, 1};
        tbl[8]  = '{2'd3, 16'h0000, 16'h0100, 1'b1, 16'h0287, 1'b1, 6, 1, 2, 1};
        tbl[9]  = '{2'd0, 16'h0A05, 16'h0100, 1'b1, 16'h0439, 1'b1, 7, 1, 2, 20};
        tbl[10] = '{2'd0, 16'h9999, 16'h0100, 1'b1, 16'h2851, 1'b1, 8, 1, 2, 20};
        tbl[11] = '{2'd0, 16'h0000, 16'h0000, 1'b1, 16'h2751, 1'b1, 9, 1, 2, 20};

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkCleared("rst");
        rst_n = 1'b1;
        @(negedge clk);
        checkCleared("idle");

        for (int i = 0; i < 12; i++) begin
            sendResult(tbl[i], 1'b1, acc);
            waitStats(acc, $sformatf("t%0d", i));
        end

        // Second result arrives mid-DABBLE and must be dropped
        v = '{2'd0, 16'h0500, 16'h0000, 1'b1, 16'h2851, 1'b1, 10, 1, 2, 20};
        sendResult(v, 1'b1, acc);
        repeat (10) @(negedge clk);
        result_valid = 1'b1;
        result_kind  = 2'd0;
        result_bcd   = 16'h0001;
        @(negedge clk);
        result_valid = 1'b0;
        chk("ovr_set", 32'(overrun), 1);
        waitStats(acc, "ovr");
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (stats_valid)
                pulses++;
        end
        chk("ovr_no_extra", 32'(pulses), 0);
        chk("ovr_trial", 32'(trial_cnt), 10);
        chk("ovr_sticky", 32'(overrun), 1);

        // clear on the same edge as an offered result
        @(negedge clk);
        result_valid = 1'b1;
        result_kind  = 2'd0;
        result_bcd   = 16'h0111;
        clear        = 1'b1;
        @(negedge clk);
        clear        = 1'b0;
        result_valid = 1'b0;
        checkCleared("clr");
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (stats_valid)
                pulses++;
        end
        chk("clr_no_stats", 32'(pulses), 0);

        v = '{2'd0, 16'h0A05, 16'h0905, 1'b1, 16'h0000, 1'b0, 1, 0, 0, 20};
        sendResult(v, 1'b1, acc);
        waitStats(acc, "clamp");

        // clear during CONV aborts the trial
        v = '{2'd0, 16'h0123, 16'h0000, 1'b0, 16'h0000, 1'b0, 0, 0, 0, 0};
        sendResult(v, 1'b0, acc);
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checkCleared("abort");
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (stats_valid)
                pulses++;
        end
        chk("abort_no_stats", 32'(pulses), 0);

        for (int i = 0; i < 256; i++) begin
            v = '{2'd1, 16'h0000, 16'h9999, 1'b0, 16'h0000, 1'b0, 0,
                  (i + 1 > 255) ? 255 : i + 1, 0, 1};
            sendResult(v, 1'b1, acc);
            waitStats(acc, $sformatf("to%0d", i));
        end
        chk("sat_tmo", 32'(timeout_cnt), 255);
        chk("sat_ovr", 32'(overrun), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
